// File: rtl/mod_addsub_pipe_if.sv
// Handshake and data bundle for the pipelined modular adder/subtractor.
// The upstream producer drives the master modport and the arithmetic block
// uses the slave modport.
interface mod_addsub_pipe_if #(
  parameter int DATA_WID = 12,
  parameter int LANES    = 4
);

  logic                      in_valid;
  logic                      in_ready;
  logic                      in_op;
  logic [LANES*DATA_WID-1:0] in_a;
  logic [LANES*DATA_WID-1:0] in_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_WID-1:0] out_sum;
  logic [LANES-1:0]          out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_err
  );

endinterface

// File: rtl/mod_addsub_pipe.sv
// mod_addsub_pipe: LANES-wide modular add/subtract (mod Q) in a two-stage
// valid/ready pipeline. Stage 1 forms the raw CLA result and a correction
// flag per lane, stage 2 folds the result back into [0, Q-1].
// Optional macro MODADD_RANGE_CHK_EN: flags lanes whose operands are >= Q,
// forcing that lane's result to 0 and raising its out_err bit. Without the
// macro no comparators are built and out_err is tied low.
module mod_addsub_pipe #(
  parameter int DATA_WID = 12,
  parameter int Q        = 3329,
  parameter int LANES    = 4
) (
  input logic              clk,
  input logic              rst,
  mod_addsub_pipe_if.slave bus
);

  localparam int RW = DATA_WID + 1;
  localparam logic [RW-1:0] QR = RW'(Q);

  logic                      w_en1;
  logic                      w_en2;
  logic [LANES-1:0][RW:0]    w_s1Add;
  logic [LANES-1:0]          w_s1Corr;
  logic [LANES*DATA_WID-1:0] w_s2Sum;

  logic                      r_s1Valid;
  logic                      r_s1Op;
  logic [LANES-1:0][RW-1:0]  r_s1Raw;
  logic [LANES-1:0]          r_s1Corr;
  logic                      r_s2Valid;
  logic [LANES*DATA_WID-1:0] r_outSum;

`ifdef MODADD_RANGE_CHK_EN
  logic [LANES-1:0] w_s1Err;
  logic [LANES-1:0] r_s1Err;
  logic [LANES-1:0] r_outErr;
`endif

  // Carry-lookahead add returning {carry_out, sum}; carries come from the
  // generate/propagate terms so the adder flattens into lookahead logic.
  function automatic logic [RW:0] claAdd(input logic [RW-1:0] x,
                                         input logic [RW-1:0] y,
                                         input logic          cin);
    logic [RW-1:0] gen;
    logic [RW-1:0] prop;
    logic [RW:0]   carry;
    gen      = x & y;
    prop     = x ^ y;
    carry    = '0;
    carry[0] = cin;
    for (int k = 0; k < RW; k++) begin
      carry[k+1] = gen[k] | (prop[k] & carry[k]);
    end
    return {carry[RW], prop ^ carry[RW-1:0]};
  endfunction

  // Back-pressure: each stage may load when it is empty or its consumer drains it.
  assign w_en2         = ~r_s2Valid | bus.out_ready;
  assign w_en1         = ~r_s1Valid | w_en2;
  assign bus.in_ready  = w_en1;
  assign bus.out_valid = r_s2Valid;
  assign bus.out_sum   = r_outSum;
`ifdef MODADD_RANGE_CHK_EN
  assign bus.out_err   = r_outErr;
`else
  assign bus.out_err   = '0;
`endif

  // Stage 1 arithmetic: subtract is a + ~b + 1, borrow is the missing carry out.
  always_comb begin
    w_s1Add  = '0;
    w_s1Corr = '0;
    for (int l = 0; l < LANES; l++) begin
      w_s1Add[l] = claAdd({1'b0, bus.in_a[l*DATA_WID +: DATA_WID]},
                          bus.in_op ? ~{1'b0, bus.in_b[l*DATA_WID +: DATA_WID]}
                                    :  {1'b0, bus.in_b[l*DATA_WID +: DATA_WID]},
                          bus.in_op);
      w_s1Corr[l] = bus.in_op ? ~w_s1Add[l][RW] : (w_s1Add[l][RW-1:0] >= QR);
    end
  end

`ifdef MODADD_RANGE_CHK_EN
  // Operand range check, one pair of comparators per lane.
  always_comb begin
    w_s1Err = '0;
    for (int l = 0; l < LANES; l++) begin
      w_s1Err[l] = ({1'b0, bus.in_a[l*DATA_WID +: DATA_WID]} >= QR) |
                   ({1'b0, bus.in_b[l*DATA_WID +: DATA_WID]} >= QR);
    end
  end
`endif

  // Stage 1 register: captures raw result, correction flag and op on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
      r_s1Op    <= 1'b0;
      r_s1Raw   <= '0;
      r_s1Corr  <= '0;
`ifdef MODADD_RANGE_CHK_EN
      r_s1Err   <= '0;
`endif
    end else if (w_en1) begin
      r_s1Valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1Op   <= bus.in_op;
        r_s1Corr <= w_s1Corr;
        for (int l = 0; l < LANES; l++) begin
          r_s1Raw[l] <= w_s1Add[l][RW-1:0];
        end
`ifdef MODADD_RANGE_CHK_EN
        r_s1Err  <= w_s1Err;
`endif
      end
    end
  end

  // Stage 2 correction: fold by -Q after an add overflow, +Q after a borrow.
  always_comb begin
    w_s2Sum = '0;
    for (int l = 0; l < LANES; l++) begin
      if (r_s1Corr[l]) begin
        w_s2Sum[l*DATA_WID +: DATA_WID] = r_s1Op ? DATA_WID'(r_s1Raw[l] + QR)
                                                 : DATA_WID'(r_s1Raw[l] - QR);
      end else begin
        w_s2Sum[l*DATA_WID +: DATA_WID] = r_s1Raw[l][DATA_WID-1:0];
      end
`ifdef MODADD_RANGE_CHK_EN
      if (r_s1Err[l]) begin
        w_s2Sum[l*DATA_WID +: DATA_WID] = '0;
      end
`endif
    end
  end

  // Stage 2 register: holds the presented result steady while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2Valid <= 1'b0;
      r_outSum  <= '0;
`ifdef MODADD_RANGE_CHK_EN
      r_outErr  <= '0;
`endif
    end else if (w_en2) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_outSum <= w_s2Sum;
`ifdef MODADD_RANGE_CHK_EN
        r_outErr <= r_s1Err;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Testbench for mod_addsub_pipe: directed vectors with literal expectations
// plus an arithmetic reference model checked on every output transfer.
// Honours MODADD_RANGE_CHK_EN the same way as the design.
module tb_mod_addsub_pipe;

  localparam int DW    = 12;
  localparam int Q     = 3329;
  localparam int LANES = 4;
  localparam int W     = DW * LANES;

  typedef struct {
    logic [W-1:0]     sum;
    logic [LANES-1:0] err;
    int               cyc;
    bit               strict;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mod_addsub_pipe_if #(.DATA_WID(DW), .LANES(LANES)) bus ();

  mod_addsub_pipe #(.DATA_WID(DW), .Q(Q), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t             q[$];
  int               nCompares     = 0;
  int               nFail         = 0;
  int               cycleCnt      = 0;
  int               outCount      = 0;
  bit               strictLat     = 1'b0;
  bit               sawInReadyLow = 1'b0;
  bit               stallPrev     = 1'b0;
  bit               randDone      = 1'b0;
  logic [W-1:0]     prevSum;
  logic [LANES-1:0] prevErr;

  always @(posedge clk) cycleCnt++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompares++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] packLanes(input int l0, input int l1, input int l2, input int l3);
    logic [W-1:0] v;
    v = '0;
    v[0*DW +: DW] = l0[DW-1:0];
    v[1*DW +: DW] = l1[DW-1:0];
    v[2*DW +: DW] = l2[DW-1:0];
    v[3*DW +: DW] = l3[DW-1:0];
    return v;
  endfunction

  // Reference: (a + b) mod Q or (a - b) mod Q per lane, straight integer arithmetic.
  function automatic logic [W-1:0] modelSum(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
    logic [W-1:0] res;
    int ai, bi, r;
    res = '0;
    for (int l = 0; l < LANES; l++) begin
      ai = int'(a[l*DW +: DW]);
      bi = int'(b[l*DW +: DW]);
      r  = op ? ((ai - bi + Q) % Q) : ((ai + bi) % Q);
`ifdef MODADD_RANGE_CHK_EN
      if (ai >= Q || bi >= Q) r = 0;
`endif
      res[l*DW +: DW] = r[DW-1:0];
    end
    return res;
  endfunction

  function automatic logic [LANES-1:0] modelErr(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [LANES-1:0] e;
    e = '0;
`ifdef MODADD_RANGE_CHK_EN
    for (int l = 0; l < LANES; l++) begin
      e[l] = (int'(a[l*DW +: DW]) >= Q) || (int'(b[l*DW +: DW]) >= Q);
    end
`endif
    return e;
  endfunction

  // Per-cycle compare process: occupancy-based ready, stall stability, in-order results.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      stallPrev = 1'b0;
    end else begin
      checkOutput("in_ready", bus.in_ready, (q.size() < 2) || bus.out_ready);
      if (!bus.in_ready) sawInReadyLow = 1'b1;
      if (stallPrev) begin
        checkOutput("stall_valid", bus.out_valid, 1);
        checkOutput("stall_sum", bus.out_sum, prevSum);
        checkOutput("stall_err", bus.out_err, prevErr);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checkOutput("out_with_empty_model", bus.out_valid, 0);
        end else begin
          e = q.pop_front();
          checkOutput("out_sum", bus.out_sum, e.sum);
          checkOutput("out_err", bus.out_err, e.err);
          if (e.strict) checkOutput("latency", cycleCnt - e.cyc, 2);
          else          checkOutput("latency_min", (cycleCnt - e.cyc) >= 2, 1);
          outCount++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.sum    = modelSum(bus.in_a, bus.in_b, bus.in_op);
        e.err    = modelErr(bus.in_a, bus.in_b);
        e.cyc    = cycleCnt;
        e.strict = strictLat;
        q.push_back(e);
      end
      stallPrev = bus.out_valid && !bus.out_ready;
      prevSum   = bus.out_sum;
      prevErr   = bus.out_err;
    end
  end

  // Presents one transaction and returns just after the edge that accepts it.
  task automatic applyStimulus(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    acc          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) checkOutput("accept_timeout", bus.in_ready, 1);
    bus.in_valid = 1'b0;
  endtask

  // Single transaction with out_ready high: nothing one cycle on, the literal result two cycles on.
  task automatic checkLiteral(input string name, input logic op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] expSum,
                              input logic [LANES-1:0] expErr);
    applyStimulus(op, a, b);
    @(negedge clk);
    checkOutput({name, "_early"}, bus.out_valid, 0);
    @(negedge clk);
    checkOutput({name, "_valid"}, bus.out_valid, 1);
    checkOutput({name, "_sum"}, bus.out_sum, expSum);
    checkOutput({name, "_err"}, bus.out_err, expErr);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] randOperand();
    logic [W-1:0] v;
    v = '0;
    for (int l = 0; l < LANES; l++) v[l*DW +: DW] = DW'($urandom_range(0, Q - 1));
    return v;
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snap;
    bus.in_valid  = 1'b0;
    bus.in_op     = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_sum", bus.out_sum, 0);
    checkOutput("rst_out_err", bus.out_err, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Directed add and subtract vectors with exact two-cycle latency
    strictLat = 1'b1;
    checkLiteral("t1_add", 1'b0, packLanes(3328, 10, 3328, 0), packLanes(1, 20, 3328, 0),
                 packLanes(0, 30, 3327, 0), '0);
    checkLiteral("t2_sub", 1'b1, packLanes(10, 0, 3328, 256), packLanes(20, 3328, 1, 256),
                 packLanes(3319, 1, 3327, 0), '0);
    checkLiteral("t2_bnd_add", 1'b0, packLanes(3328, 3328, 0, 5), packLanes(3328, 1, 0, 7),
                 packLanes(3327, 0, 0, 12), '0);
    checkLiteral("t2_bnd_sub", 1'b1, packLanes(0, 0, 5, 3328), packLanes(0, 3328, 7, 3328),
                 packLanes(0, 1, 3327, 0), '0);
    strictLat = 1'b0;

    // 8 back-to-back transactions, consumer stalls for cycles 3-7
    snap          = outCount;
    sawInReadyLow = 1'b0;
    fork
      begin
        for (int t = 0; t < 8; t++) applyStimulus(t[0], randOperand(), randOperand());
      end
      begin
        for (int c = 0; c < 15; c++) begin
          bus.out_ready = !(c >= 3 && c <= 7);
          @(posedge clk);
          #1;
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("t3_count", outCount - snap, 8);
    checkOutput("t3_drained", q.size(), 0);
    checkOutput("t3_backpressure", sawInReadyLow, 1);

    // Reset with two transactions in flight
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, packLanes(1, 2, 3, 4), packLanes(5, 6, 7, 8));
    applyStimulus(1'b1, packLanes(9, 9, 9, 9), packLanes(1, 1, 1, 1));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("t4_out_valid", bus.out_valid, 0);
    checkOutput("t4_out_sum", bus.out_sum, 0);
    checkOutput("t4_out_err", bus.out_err, 0);
    checkOutput("t4_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    snap          = outCount;
    strictLat     = 1'b1;
    checkLiteral("t4_after", 1'b0, packLanes(100, 200, 3000, 1), packLanes(50, 3200, 329, 3327),
                 packLanes(150, 71, 0, 3328), '0);
    strictLat     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("t4_count", outCount - snap, 1);

`ifdef MODADD_RANGE_CHK_EN
    // Range error isolated to lane 1
    @(posedge clk);
    #1;
    checkLiteral("t5_range", 1'b0, packLanes(1, 3329, 100, 200), packLanes(2, 0, 300, 400),
                 packLanes(3, 0, 400, 600), 4'b0010);
`endif

    // Random regression with random gaps and random consumer stalls
    @(posedge clk);
    #1;
    snap     = outCount;
    randDone = 1'b0;
    fork
      begin
        for (int t = 0; t < 300; t++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          applyStimulus(1'($urandom_range(0, 1)), randOperand(), randOperand());
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("t6_count", outCount - snap, 300);
    checkOutput("t6_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nCompares, nFail);
    $finish;
  end

endmodule
